digit_entry_buffer: RTL and testbench
=====================================

# digit_entry_buffer

Front-end stage of the password lock that converts the ten raw digit switches into a buffered multi-digit code for the lock FSM. It sits between the board switches and the FSM controller. It filters switch bounce, accepts one digit per raise-and-lower gesture, and supports backspace and clear. On confirm it presents a complete code with a one-cycle valid strobe. It also drives the entered-digits view used by the 7-segment display.

## Interface
Parameters:
- `DIGITS`, 4: maximum code length in digits.
- `STABLE_CYCLES`, 1_000_000: cycles a switch pattern must hold unchanged before it is accepted (10 ms at 100 MHz). Minimum value is 2.

Ports:
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  synchronous, active-high reset.
- `sw_nums`  in  10  raw, asynchronous digit switches; bit k = digit k.
- `enable`  in  1  high while the FSM is in a code-entry mode (user input or admin set).
- `backspace`  in  1  debounced 1-cycle pulse; removes the last digit.
- `clear`  in  1  1-cycle pulse; empties the buffer.
- `confirm`  in  1  debounced 1-cycle pulse; submits the code.
- `code_out`  out  4*DIGITS  BCD buffer contents; the newest digit is in nibble [3:0].
- `code_len`  out  $clog2(DIGITS+1)  number of digits currently held.
- `code_valid`  out  1  1-cycle strobe; `code_out`/`code_len` hold the submitted code during this cycle.
- `digit_pulse`  out  1  1-cycle strobe, asserted when a digit is appended.
- `entry_error`  out  1  1-cycle strobe on any rejected event.

## Operation
- Settle path: `sw_nums` passes through a 2-flop synchronizer, then a stability counter. The pattern is accepted as `stable_pat` once it has been unchanged for `STABLE_CYCLES` cycles. Any change restarts the count.
- Gesture FSM, two states:
  - ARMED → HELD when `stable_pat` becomes non-zero.
    - Exactly one bit set: a digit event with value = index of that bit.
    - More than one bit set: an `entry_error` event.
  - HELD → ARMED when `stable_pat` returns to zero.
  - Further pattern changes while in HELD produce no events.
- Digit event with `enable`=1:
  - If `code_len` < `DIGITS`: shift the buffer left by 4 bits, insert the digit at [3:0], increment `code_len`, pulse `digit_pulse`.
  - If `code_len` = `DIGITS` (buffer full): pulse `entry_error`; the buffer is unchanged.
- Backspace: shift right by 4 bits, zero-fill the top nibble, decrement `code_len`. If `code_len` = 0, this is a no-op with no error.
- Confirm:
  - With `code_len` > 0: `code_valid`=1 in the next cycle with the buffer unchanged. The buffer and `code_len` clear in the cycle after that.
  - With `code_len` = 0: pulse `entry_error` only.
- Same-cycle priority, highest first: `clear` > `confirm` > `backspace` > digit event. Lower-priority events in that cycle are discarded, not deferred. A discarded digit still moves the FSM to HELD.
- Behaviour with `enable`=0:
  - The buffer is held at zero and `code_len` is 0.
  - `backspace`, `confirm` and `clear` are ignored.
  - The gesture FSM keeps tracking, so a switch that is already up when entry mode starts is not accepted.
- Out-of-range values: `code_out` nibbles never exceed 9; unused nibbles are 0.

## Timing
- Reset values:
  - Outputs: all 0.
  - Gesture FSM: HELD.
  - `stable_pat`: 10'h3FF. This forces a switch to be seen all-zero before the first digit can be accepted.
  - Counter: 0.
- Digit latency: `digit_pulse` and the buffer update occur exactly `STABLE_CYCLES`+3 cycles after the new pattern first appears on `sw_nums`, provided the pattern holds for that whole period. Breakdown: 2 synchronizer cycles, `STABLE_CYCLES` counting cycles, 1 event register.
- Backspace and clear take effect on the cycle after the pulse.
- Confirm: `code_valid` occurs 1 cycle after `confirm`; the clear occurs 2 cycles after.
- `rst` asserted mid-count or mid-confirm discards everything, including a pending `code_valid`.
- Strobes are never wider than 1 cycle. At most one of `digit_pulse`/`entry_error` is asserted per cycle.

## Structure
- Shared package `lock_pkg`:
  - `DIGIT_W`=4.
  - Gesture state enum {ARMED, HELD}.
  - Function `onehot_to_bcd`.
  - Function `is_onehot`.
  - The fsm_controller uses the same package for code comparison.
- Sub-module `switch_settle`: the synchronizer plus the stability counter. It outputs `stable_pat` and a 1-cycle `pat_changed` strobe.
- The buffer, priority logic and gesture FSM stay in the top of this block.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `DIGITS`=4.
- Reset with `sw_nums`=10'h008 held, then `enable`=1 → no `digit_pulse`. Lower to 0, then raise bit 3 → `digit_pulse` 7 cycles after the raise; `code_out`=16'h0003, `code_len`=1.
- Enter 1,2,3,4 via four gestures, then a fifth digit 5 → `code_out`=16'h1234, `code_len`=4, one `entry_error`, buffer unchanged.
- Bounce: toggle bit 2 every 2 cycles for 20 cycles, then hold high → exactly one digit 2, accepted 7 cycles after the last toggle.
- Raise bits 1 and 5 together → `entry_error` at the 7th cycle, no digit. After they are lowered, bit 6 → digit 6 accepted.
- Buffer 1234, `backspace` → 16'h0123, len 3. `confirm` → `code_valid` next cycle with 16'h0123, len 3; 0/0 the cycle after. Confirm at len 0 → `entry_error` only.
- `clear` and `confirm` in the same cycle with buffer 0012 → no `code_valid`, buffer 0 next cycle. Assert `rst` between `confirm` and `code_valid` → no strobe.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the password lock: digit width, gesture states and
// switch-pattern helpers used by the entry buffer and the lock controller.
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SW_W    = 10;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } gesture_e;

  // Index of the highest set bit; a one-hot input yields its digit value.
  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [SW_W-1:0] pat);
    logic [DIGIT_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < int'(SW_W); i++) begin
      if (pat[i]) bcd = DIGIT_W'(i);
    end
    return bcd;
  endfunction

  function automatic logic is_onehot(input logic [SW_W-1:0] pat);
    return (pat != '0) && ((pat & (pat - SW_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/switch_settle.sv
// Synchronises the raw digit switches and accepts a pattern only after it has
// held unchanged for STABLE_CYCLES cycles.
module switch_settle
  import lock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_nums,
  output logic [SW_W-1:0] stable_pat,
  output logic            pat_changed
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SW_W-1:0]  sync1;
  logic [SW_W-1:0]  sync2;
  logic [SW_W-1:0]  last;
  logic [CNT_W-1:0] cnt;
  logic             moved;
  logic             settled;

  // cnt holds the run length of the synchronised value so far, capped at CNT_LAST.
  assign moved   = (sync2 != last);
  assign settled = !moved && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      last        <= '0;
      cnt         <= '0;
      stable_pat  <= '1;
      pat_changed <= 1'b0;
    end else begin
      sync1       <= sw_nums;
      sync2       <= sync1;
      last        <= sync2;
      pat_changed <= 1'b0;
      if (moved) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (settled) begin
        stable_pat  <= sync2;
        pat_changed <= (sync2 != stable_pat);
      end
    end
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Turns debounced switch gestures plus backspace/clear/confirm pulses into a
// buffered BCD code, newest digit in the low nibble, for the lock controller.
module digit_entry_buffer
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   sw_nums,
  input  logic                         enable,
  input  logic                         backspace,
  input  logic                         clear,
  input  logic                         confirm,
  output logic [DIGIT_W*DIGITS-1:0]    code_out,
  output logic [$clog2(DIGITS+1)-1:0]  code_len,
  output logic                         code_valid,
  output logic                         digit_pulse,
  output logic                         entry_error
);

  localparam int unsigned CODE_W = DIGIT_W * DIGITS;
  localparam int unsigned LEN_W  = $clog2(DIGITS + 1);

  logic [SW_W-1:0]   stable_pat;
  logic              pat_changed;
  gesture_e          state;
  gesture_e          state_n;
  logic              digit_ev;
  logic              error_ev;
  logic              pend_clear;
  logic              pend_clear_n;
  logic [CODE_W-1:0] code_n;
  logic [LEN_W-1:0]  len_n;
  logic              valid_n;
  logic              digit_n;
  logic              error_n;

  switch_settle #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .sw_nums    (sw_nums),
    .stable_pat (stable_pat),
    .pat_changed(pat_changed)
  );

  // Gesture tracking plus the clear > confirm > backspace > digit priority chain.
  always_comb begin
    state_n      = state;
    digit_ev     = 1'b0;
    error_ev     = 1'b0;
    code_n       = code_out;
    len_n        = code_len;
    valid_n      = 1'b0;
    digit_n      = 1'b0;
    error_n      = 1'b0;
    pend_clear_n = 1'b0;

    case (state)
      ARMED: begin
        if (pat_changed && (stable_pat != '0)) begin
          state_n  = HELD;
          digit_ev = is_onehot(stable_pat);
          error_ev = !is_onehot(stable_pat);
        end
      end
      HELD: begin
        if (stable_pat == '0) state_n = ARMED;
      end
      default: state_n = HELD;
    endcase

    if (!enable || pend_clear || clear) begin
      code_n = '0;
      len_n  = '0;
    end else if (confirm) begin
      if (code_len != '0) begin
        valid_n      = 1'b1;
        pend_clear_n = 1'b1;
      end else begin
        error_n = 1'b1;
      end
    end else if (backspace) begin
      if (code_len != '0) begin
        code_n = {DIGIT_W'(0), code_out[CODE_W-1:DIGIT_W]};
        len_n  = code_len - LEN_W'(1);
      end
    end else if (digit_ev) begin
      if (code_len < LEN_W'(DIGITS)) begin
        code_n  = {code_out[CODE_W-DIGIT_W-1:0], onehot_to_bcd(stable_pat)};
        len_n   = code_len + LEN_W'(1);
        digit_n = 1'b1;
      end else begin
        error_n = 1'b1;
      end
    end else if (error_ev) begin
      error_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HELD;
      code_out    <= '0;
      code_len    <= '0;
      code_valid  <= 1'b0;
      digit_pulse <= 1'b0;
      entry_error <= 1'b0;
      pend_clear  <= 1'b0;
    end else begin
      state       <= state_n;
      code_out    <= code_n;
      code_len    <= len_n;
      code_valid  <= valid_n;
      digit_pulse <= digit_n;
      entry_error <= error_n;
      pend_clear  <= pend_clear_n;
    end
  end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: directed gestures followed by random switch and
// pulse traffic, all checked every cycle against a queue-based reference model.
module tb_digit_entry_buffer;

  localparam int S      = 4;
  localparam int D      = 4;
  localparam int HIST_N = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw_nums;
  logic        enable;
  logic        backspace;
  logic        clear;
  logic        confirm;
  logic [15:0] code_out;
  logic [2:0]  code_len;
  logic        code_valid;
  logic        digit_pulse;
  logic        entry_error;

  digit_entry_buffer #(
    .DIGITS       (D),
    .STABLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_nums    (sw_nums),
    .enable     (enable),
    .backspace  (backspace),
    .clear      (clear),
    .confirm    (confirm),
    .code_out   (code_out),
    .code_len   (code_len),
    .code_valid (code_valid),
    .digit_pulse(digit_pulse),
    .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_dp   = 0;
  int n_ee   = 0;

  // Reference model: switch sample history per edge, accepted pattern, a digit queue.
  logic [10:0] hist [0:HIST_N-1];
  int          e = 10;
  logic [9:0]  m_stab;
  logic        m_armed;
  logic        m_pend;
  logic        m_cv;
  logic        m_dp;
  logic        m_ee;
  int          q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  task automatic model_edge();
    logic        nz;
    logic        one;
    logic        dig;
    logic        err;
    logic        same;
    logic [3:0]  val;
    logic [10:0] ref_s;
    e++;
    m_cv = 1'b0;
    m_dp = 1'b0;
    m_ee = 1'b0;
    if (rst) begin
      hist[e]   = 11'h000;
      hist[e-1] = 11'h000;
      hist[e-2] = 11'h400;
      m_stab    = 10'h3FF;
      m_armed   = 1'b0;
      m_pend    = 1'b0;
      q.delete();
      return;
    end
    hist[e] = {1'b0, sw_nums};
    nz  = (m_stab != 10'h000);
    one = ($countones(m_stab) == 1);
    val = 4'h0;
    for (int k = 0; k < 10; k++) if (m_stab[k]) val = 4'(k);
    dig = m_armed && nz && one;
    err = m_armed && nz && !one;
    if (m_armed && nz) m_armed = 1'b0;
    else if (!m_armed && !nz) m_armed = 1'b1;

    if (!enable || m_pend || clear) begin
      q.delete();
      m_pend = 1'b0;
    end else if (confirm) begin
      if (q.size() > 0) begin
        m_cv   = 1'b1;
        m_pend = 1'b1;
      end else m_ee = 1'b1;
    end else if (backspace) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (dig) begin
      if (q.size() < D) begin
        q.push_back(int'(val));
        m_dp = 1'b1;
      end else m_ee = 1'b1;
    end else if (err) begin
      m_ee = 1'b1;
    end

    // A pattern is accepted once S consecutive synchronised samples agree.
    ref_s = hist[e-2];
    same  = !ref_s[10];
    for (int k = e - 1 - S; k <= e - 2; k++) if (hist[k] !== ref_s) same = 1'b0;
    if (same) m_stab = ref_s[9:0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    n_dp += int'(digit_pulse);
    n_ee += int'(entry_error);
    check("code_out", 32'(code_out), 32'(model_code()));
    check("code_len", 32'(code_len), 32'(q.size()));
    check("code_valid", 32'(code_valid), 32'(m_cv));
    check("digit_pulse", 32'(digit_pulse), 32'(m_dp));
    check("entry_error", 32'(entry_error), 32'(m_ee));
    backspace = 1'b0;
    clear     = 1'b0;
    confirm   = 1'b0;
  endtask

  task automatic gesture(input logic [9:0] pat);
    sw_nums = pat;
    repeat (9) step();
    sw_nums = 10'h000;
    repeat (9) step();
  endtask

  int hold_left;
  int r;
  int base;

  initial begin
    rst       = 1'b1;
    sw_nums   = 10'h008;
    enable    = 1'b0;
    backspace = 1'b0;
    clear     = 1'b0;
    confirm   = 1'b0;
    repeat (2) step();
    check("rst_code", 32'(code_out), 32'h0);
    check("rst_len", 32'(code_len), 32'h0);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (12) step();
    check("held_at_reset_no_digit", 32'(n_dp), 32'h0);

    sw_nums = 10'h000;
    repeat (8) step();
    sw_nums = 10'h008;
    repeat (6) step();
    check("latency_early", 32'(digit_pulse), 32'h0);
    step();
    check("latency_pulse", 32'(digit_pulse), 32'h1);
    check("first_code", 32'(code_out), 32'h0003);
    check("first_len", 32'(code_len), 32'h1);
    repeat (2) step();
    sw_nums = 10'h000;
    repeat (9) step();
    clear = 1'b1;
    step();
    check("clear_len", 32'(code_len), 32'h0);

    for (int d = 1; d <= 4; d++) gesture(10'h001 << d);
    check("four_code", 32'(code_out), 32'h1234);
    check("four_len", 32'(code_len), 32'h4);
    base = n_ee;
    gesture(10'h020);
    check("full_err_count", 32'(n_ee - base), 32'h1);
    check("full_code_kept", 32'(code_out), 32'h1234);

    backspace = 1'b1;
    step();
    check("bksp_code", 32'(code_out), 32'h0123);
    check("bksp_len", 32'(code_len), 32'h3);
    confirm = 1'b1;
    step();
    check("confirm_valid", 32'(code_valid), 32'h1);
    check("confirm_code", 32'(code_out), 32'h0123);
    check("confirm_len", 32'(code_len), 32'h3);
    step();
    check("confirm_after_valid", 32'(code_valid), 32'h0);
    check("confirm_after_code", 32'(code_out), 32'h0);
    check("confirm_after_len", 32'(code_len), 32'h0);
    confirm = 1'b1;
    step();
    check("confirm_empty_err", 32'(entry_error), 32'h1);
    check("confirm_empty_valid", 32'(code_valid), 32'h0);

    base = n_dp;
    for (int i = 0; i < 10; i++) begin
      sw_nums = (i % 2 == 0) ? 10'h004 : 10'h000;
      repeat (2) step();
    end
    sw_nums = 10'h004;
    repeat (6) step();
    check("bounce_early", 32'(digit_pulse), 32'h0);
    step();
    check("bounce_pulse", 32'(digit_pulse), 32'h1);
    check("bounce_code", 32'(code_out), 32'h0002);
    sw_nums = 10'h000;
    repeat (9) step();
    check("bounce_once", 32'(n_dp - base), 32'h1);

    clear = 1'b1;
    step();
    sw_nums = 10'h022;
    repeat (6) step();
    check("multi_early", 32'(entry_error), 32'h0);
    step();
    check("multi_err", 32'(entry_error), 32'h1);
    check("multi_no_digit", 32'(code_len), 32'h0);
    repeat (2) step();
    sw_nums = 10'h000;
    repeat (9) step();
    sw_nums = 10'h040;
    repeat (7) step();
    check("after_multi_pulse", 32'(digit_pulse), 32'h1);
    check("after_multi_code", 32'(code_out), 32'h0006);
    sw_nums = 10'h000;
    repeat (9) step();

    clear = 1'b1;
    step();
    gesture(10'h002);
    gesture(10'h004);
    check("pair_code", 32'(code_out), 32'h0012);
    clear   = 1'b1;
    confirm = 1'b1;
    step();
    check("clear_beats_confirm_valid", 32'(code_valid), 32'h0);
    check("clear_beats_confirm_code", 32'(code_out), 32'h0);
    gesture(10'h080);
    confirm = 1'b1;
    rst     = 1'b1;
    step();
    check("rst_kills_valid", 32'(code_valid), 32'h0);
    rst = 1'b0;
    step();
    check("rst_kills_valid_late", 32'(code_valid), 32'h0);

    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) sw_nums = 10'h000;
        else if (r < 8) sw_nums = 10'h001 << $urandom_range(0, 9);
        else sw_nums = 10'($urandom);
        hold_left = int'($urandom_range(1, 12));
      end
      hold_left--;
      backspace = ($urandom_range(0, 29) == 0);
      clear     = ($urandom_range(0, 79) == 0);
      confirm   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 199) == 0) enable = !enable;
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
